// File: rtl/msk_and_hpc2_stream.sv
// Masked AND gadget (HPC2 style, aligned inputs) as a two-stage valid/ready stream.
// Shares of lane l sit at bit s*W+l; each accepted operation consumes one fresh rnd word.
module msk_and_hpc2_stream #(
    parameter int d = 2,
    parameter int W = 1,
    localparam int NRND = W*d*(d-1)/2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W*d-1:0]    ina,
    input  logic [W*d-1:0]    inb,
    input  logic [NRND-1:0]   rnd,
    input  logic              rnd_valid,
    output logic              rnd_ready,
    output logic [W*d-1:0]    out,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int P  = d*(d-1)/2;
    localparam int WD = W*d;
    localparam int WM = W*d*d;

    logic            s1_valid;
    logic            s2_valid;
    logic            fire;
    logic            adv2;

    logic [WD-1:0]   a_reg;
    logic [WD-1:0]   b_reg;
    logic [NRND-1:0] r_reg;
    logic [WM-1:0]   v_reg;
    logic [WD-1:0]   aibi_reg;
    logic [WM-1:0]   u_reg;
    logic [WM-1:0]   w_reg;

    // Cross-term matrices indexed (lane*d + i)*d + j; diagonal entries are tied to zero.
    logic [WM-1:0]   v_next;
    logic [WM-1:0]   r_s1_m;
    logic [WM-1:0]   u_next;
    logic [WM-1:0]   w_next;

    assign in_ready  = !s1_valid | !s2_valid | out_ready;
    assign fire      = in_valid & rnd_valid & in_ready;
    assign rnd_ready = in_valid & in_ready;
    assign adv2      = s1_valid & (!s2_valid | out_ready);
    assign out_valid = s2_valid;

    genvar gl, gi, gj;
    generate
        for (gl = 0; gl < W; gl++) begin : g_lane
            for (gi = 0; gi < d; gi++) begin : g_row
                localparam int SB = gi*W + gl;
                localparam int MB = (gl*d + gi)*d;
                for (gj = 0; gj < d; gj++) begin : g_col
                    localparam int M = MB + gj;
                    if (gi == gj) begin : g_diag
                        assign v_next[M] = 1'b0;
                        assign r_s1_m[M] = 1'b0;
                    end else begin : g_pair
                        // r_ij and r_ji share one random bit, stored once per unordered pair.
                        localparam int LO = (gi < gj) ? gi : gj;
                        localparam int HI = (gi < gj) ? gj : gi;
                        localparam int R  = gl*P + LO*d - LO*(LO+1)/2 + (HI-1-LO);
                        assign v_next[M] = inb[gj*W + gl] ^ rnd[R];
                        assign r_s1_m[M] = r_reg[R];
                    end
                    assign u_next[M] = ~a_reg[SB] & r_s1_m[M];
                    assign w_next[M] =  a_reg[SB] & v_reg[M];
                end
                assign out[SB] = aibi_reg[SB] ^ (^(u_reg[MB +: d] ^ w_reg[MB +: d]));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            r_reg    <= '0;
            v_reg    <= '0;
            aibi_reg <= '0;
            u_reg    <= '0;
            w_reg    <= '0;
        end else begin
            s1_valid <= fire | (s1_valid & !adv2);
            s2_valid <= adv2 | (s2_valid & !out_ready);
            if (fire) begin
                a_reg <= ina;
                b_reg <= inb;
                r_reg <= rnd;
                v_reg <= v_next;
            end
            // Stage 2 only moves on adv2 so a stalled result never mixes with newer stage-1 data.
            if (adv2) begin
                aibi_reg <= a_reg & b_reg;
                u_reg    <= u_next;
                w_reg    <= w_next;
            end
        end
    end
endmodule

// File: tb/tb_msk_and_hpc2_stream.sv
// Scoreboard bench for msk_and_hpc2_stream: main instance d=3/W=4, small instance d=2/W=1.
`timescale 1ns/1ps
module tb_msk_and_hpc2_stream;
    localparam int D  = 3;
    localparam int W  = 4;
    localparam int WD = W*D;
    localparam int P  = D*(D-1)/2;
    localparam int NR = W*P;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WD-1:0] ina = '0;
    logic [WD-1:0] inb = '0;
    logic [NR-1:0] rnd = '0;
    logic          rnd_valid = 1'b0;
    logic          rnd_ready;
    logic [WD-1:0] out;
    logic          out_valid;
    logic          out_ready = 1'b1;

    logic          b_in_valid = 1'b0;
    logic          b_in_ready;
    logic [1:0]    b_ina = '0;
    logic [1:0]    b_inb = '0;
    logic [0:0]    b_rnd = '0;
    logic          b_rnd_valid = 1'b0;
    logic          b_rnd_ready;
    logic [1:0]    b_out;
    logic          b_out_valid;
    logic          b_out_ready = 1'b1;

    msk_and_hpc2_stream #(.d(D), .W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ina(ina), .inb(inb), .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .out(out), .out_valid(out_valid), .out_ready(out_ready)
    );

    msk_and_hpc2_stream #(.d(2), .W(1)) dut_small (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .ina(b_ina), .inb(b_inb), .rnd(b_rnd), .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready),
        .out(b_out), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WD-1:0] o;
        logic [W-1:0]  p;
        int            c;
    } item_t;

    item_t sb[$];
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int fire_cnt = 0;
    int pop_cnt = 0;
    int rnd_id = 0;
    int last_rnd_id = -1;
    bit check_lat = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Share-level reference: out_i = a_i b_i ^ XOR_{j!=i} (r_ij ^ a_i b_j).
    function automatic logic [WD-1:0] model(input logic [WD-1:0] a, input logic [WD-1:0] b,
                                            input logic [NR-1:0] r);
        logic [WD-1:0] res;
        res = '0;
        for (int l = 0; l < W; l++) begin
            for (int i = 0; i < D; i++) begin
                logic acc;
                acc = a[i*W+l] & b[i*W+l];
                for (int j = 0; j < D; j++) begin
                    if (j != i) begin
                        int lo, hi, idx;
                        lo  = (i < j) ? i : j;
                        hi  = (i < j) ? j : i;
                        idx = l*P + lo*D - lo*(lo+1)/2 + (hi-1-lo);
                        acc = acc ^ r[idx] ^ (a[i*W+l] & b[j*W+l]);
                    end
                end
                res[i*W+l] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [W-1:0] unmask(input logic [WD-1:0] x);
        logic [W-1:0] res;
        res = '0;
        for (int s = 0; s < D; s++) res = res ^ x[s*W +: W];
        return res;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Monitor: push on fire, pop on output handshake, hold/rnd checks every cycle.
    initial begin
        item_t it;
        bit hold_pending;
        logic [WD-1:0] held_out;
        hold_pending = 1'b0;
        held_out = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                hold_pending = 1'b0;
            end else begin
                if (hold_pending && out_valid) check_eq("hold_stable", out, held_out);
                check_eq("rnd_ready", rnd_ready, in_valid & in_ready);
                if (rnd_valid && rnd_ready) begin
                    check_eq("rnd_fresh", rnd_id != last_rnd_id, 1);
                    last_rnd_id = rnd_id;
                end
                if (in_valid && rnd_valid && in_ready) begin
                    it.o = model(ina, inb, rnd);
                    it.p = unmask(ina) & unmask(inb);
                    it.c = cyc;
                    sb.push_back(it);
                    fire_cnt++;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check_eq("unexpected_out", 1, 0);
                    end else begin
                        it = sb.pop_front();
                        check_eq("shares", out, it.o);
                        check_eq("plain", unmask(out), it.p);
                        if (check_lat) check_eq("latency", cyc - it.c, 2);
                        $display("[TB] result %0d out=%h plain=%h", pop_cnt, out, unmask(out));
                        pop_cnt++;
                    end
                end
                hold_pending = out_valid && !out_ready;
                held_out = out;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WD-1:0] a, input logic [WD-1:0] b, input logic [NR-1:0] r);
        bit acc;
        int n;
        ina = a; inb = b; rnd = r; rnd_id++;
        in_valid = 1'b1; rnd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) check_eq("send_timeout", 0, 1);
        in_valid = 1'b0; rnd_valid = 1'b0;
    endtask

    function automatic logic [WD-1:0] rnd_wd();
        return WD'($urandom);
    endfunction

    initial begin
        int start, fc0, pc0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_out", out, 0);
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_in_ready", in_ready, 1);
        check_eq("reset_small_out_valid", b_out_valid, 0);
        tick();

        // d=2 vector: a=01, b=11, r=1 -> shares 11 (unmasked 0), two cycles after fire.
        b_ina = 2'b01; b_inb = 2'b11; b_rnd = 1'b1; b_in_valid = 1'b1; b_rnd_valid = 1'b1;
        @(negedge clk);
        check_eq("small_fire", b_in_ready, 1);
        tick();
        b_in_valid = 1'b0; b_rnd_valid = 1'b0;
        @(negedge clk);
        check_eq("small_t1_valid", b_out_valid, 0);
        tick();
        @(negedge clk);
        check_eq("small_t2_valid", b_out_valid, 1);
        check_eq("small_t2_out", b_out, 2'b11);
        tick();
        @(negedge clk);
        check_eq("small_t3_valid", b_out_valid, 0);
        tick();

        // Back-to-back random stream, one op per cycle.
        check_lat = 1'b1;
        out_ready = 1'b1;
        start = cyc;
        for (int k = 0; k < 1000; k++) send(rnd_wd(), rnd_wd(), NR'($urandom));
        check_eq("throughput_cycles", cyc - start, 1000);
        repeat (4) tick();
        check_eq("stream_drained", pop_cnt, 1001 - 1);

        // Output stall: three ops offered, only two fit.
        check_lat = 1'b0;
        out_ready = 1'b0;
        fc0 = fire_cnt; pc0 = pop_cnt;
        send(rnd_wd(), rnd_wd(), NR'($urandom));
        send(rnd_wd(), rnd_wd(), NR'($urandom));
        ina = rnd_wd(); inb = rnd_wd(); rnd = NR'($urandom); rnd_id++;
        in_valid = 1'b1; rnd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("stall_in_ready", in_ready, 0);
            check_eq("stall_out_valid", out_valid, 1);
            tick();
        end
        check_eq("stall_accepted", fire_cnt - fc0, 2);
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("release_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0; rnd_valid = 1'b0;
        repeat (5) tick();
        check_eq("stall_results", pop_cnt - pc0, 3);

        // Randomness starvation.
        check_lat = 1'b1;
        fc0 = fire_cnt; pc0 = pop_cnt;
        ina = rnd_wd(); inb = rnd_wd(); rnd = NR'($urandom); rnd_id++;
        in_valid = 1'b1; rnd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("starve_rnd_ready", rnd_ready, 1);
            check_eq("starve_out_valid", out_valid, 0);
            tick();
        end
        check_eq("starve_no_fire", fire_cnt - fc0, 0);
        rnd_valid = 1'b1;
        tick();
        in_valid = 1'b0; rnd_valid = 1'b0;
        repeat (4) tick();
        check_eq("starve_result", pop_cnt - pc0, 1);

        // Reset one cycle after fire drops the operation.
        pc0 = pop_cnt;
        send(rnd_wd(), rnd_wd(), NR'($urandom));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("midrst_out_valid", out_valid, 0);
            check_eq("midrst_out", out, 0);
            check_eq("midrst_in_ready", in_ready, 1);
            tick();
        end

        // Reset wins over a simultaneous fire.
        ina = rnd_wd(); inb = rnd_wd(); rnd = NR'($urandom); rnd_id++;
        in_valid = 1'b1; rnd_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("rstprio_out_valid", out_valid, 0);
            tick();
        end
        check_eq("reset_no_results", pop_cnt - pc0, 0);
        check_eq("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
